overture_io_port: RTL and testbench

Level-side I/O responder for the 8-bit OVERTURE core. It answers the core's architectural input strobe with bytes from a host-fed input FIFO. It captures every architectural output strobe into an output FIFO drained by the host. It sits between the CPU top level and the test harness or host, and provides sticky underflow/overflow flags plus a stall hint for future stall-capable cores.

---
 rtl/overture_io_port.sv | 100 ++++++++++
 tb/tb_overture_io_port.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/overture_io_port.sv
// overture_io_port: host-fed input FIFO and host-drained output FIFO for the OVERTURE core strobes
module overture_io_port #(
   parameter int UUID  = 0,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arch_input_enable,
   output logic [7:0]    arch_input_value,
   input  logic          arch_output_enable,
   input  logic [7:0]    arch_output_value,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic [CW-1:0] in_count,
   output logic [CW-1:0] out_count,
   output logic          cpu_stall,
   output logic          in_underflow,
   output logic          out_overflow,
   input  logic          clear_flags
);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || UUID < 0) begin : g_bad_param
      $error("overture_io_port: DEPTH must be a power of two >= 2 and UUID non-negative");
   end

   logic [7:0]    in_mem_q  [DEPTH];
   logic [7:0]    out_mem_q [DEPTH];
   logic [AW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
   logic [AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic          in_underflow_q, in_underflow_d, out_overflow_q, out_overflow_d;
   logic          in_empty, in_push, in_pop, out_full, out_push, out_pop, out_drop;

   // Handshake decode; the core never reads a byte pushed in the same cycle (no bypass)
   always_comb begin
      in_empty         = in_cnt_q == '0;
      in_ready         = in_cnt_q != CW'(DEPTH);
      in_push          = in_valid & in_ready;
      in_pop           = arch_input_enable & ~in_empty;
      arch_input_value = in_pop ? in_mem_q[in_rp_q] : 8'h00;
      cpu_stall        = arch_input_enable & in_empty;
      out_valid        = out_cnt_q != '0;
      out_full         = out_cnt_q == CW'(DEPTH);
      out_pop          = out_valid & out_ready;
      out_push         = arch_output_enable & (~out_full | out_pop);
      out_drop         = arch_output_enable & out_full & ~out_pop;
      out_data         = out_valid ? out_mem_q[out_rp_q] : 8'h00;
      in_count         = in_cnt_q;
      out_count        = out_cnt_q;
      in_underflow     = in_underflow_q;
      out_overflow     = out_overflow_q;
   end

   // Next-state for pointers, counts and sticky flags (a set event beats clear_flags)
   always_comb begin
      in_wp_d        = in_wp_q + AW'(in_push);
      in_rp_d        = in_rp_q + AW'(in_pop);
      in_cnt_d       = in_cnt_q + CW'(in_push) - CW'(in_pop);
      out_wp_d       = out_wp_q + AW'(out_push);
      out_rp_d       = out_rp_q + AW'(out_pop);
      out_cnt_d      = out_cnt_q + CW'(out_push) - CW'(out_pop);
      in_underflow_d = cpu_stall | (in_underflow_q & ~clear_flags);
      out_overflow_d = out_drop | (out_overflow_q & ~clear_flags);
   end

   // Control state register; reset flushes both FIFOs and ignores that cycle's strobes
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_wp_q        <= '0;
         in_rp_q        <= '0;
         in_cnt_q       <= '0;
         out_wp_q       <= '0;
         out_rp_q       <= '0;
         out_cnt_q      <= '0;
         in_underflow_q <= 1'b0;
         out_overflow_q <= 1'b0;
      end else begin
         in_wp_q        <= in_wp_d;
         in_rp_q        <= in_rp_d;
         in_cnt_q       <= in_cnt_d;
         out_wp_q       <= out_wp_d;
         out_rp_q       <= out_rp_d;
         out_cnt_q      <= out_cnt_d;
         in_underflow_q <= in_underflow_d;
         out_overflow_q <= out_overflow_d;
      end
   end

   // Storage writes; contents need no reset since counts gate every read
   always_ff @(posedge clk) begin
      if (rst && in_push) in_mem_q[in_wp_q] <= in_data;
      if (rst && out_push) out_mem_q[out_wp_q] <= arch_output_value;
   end
endmodule

// File: tb/tb_overture_io_port.sv
// tb_overture_io_port: directed and random checks of overture_io_port against a queue model
module tb_overture_io_port;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          aie = 1'b0, aoe = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
   logic [7:0]    aov = 8'h00, in_data = 8'h00;
   logic [7:0]    arch_input_value, out_data;
   logic          in_ready, out_valid, cpu_stall, in_underflow, out_overflow;
   logic [CW-1:0] in_count, out_count;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] in_q[$];
   logic [7:0] out_q[$];
   bit         m_uf = 1'b0, m_of = 1'b0;
   logic [7:0] last_aiv, last_od;
   logic       last_ir, last_stall;

   overture_io_port #(.UUID(3), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .arch_input_enable(aie), .arch_input_value(arch_input_value),
      .arch_output_enable(aoe), .arch_output_value(aov),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .in_count(in_count), .out_count(out_count),
      .cpu_stall(cpu_stall), .in_underflow(in_underflow), .out_overflow(out_overflow),
      .clear_flags(clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      aie = 1'b0; aoe = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; rst = 1'b1;
   endtask

   // one clock: check combinational/state outputs before the edge, update model, check after
   task automatic tick();
      int         isz, osz;
      bit         ipop, ipush, opop, under, drop;
      logic [7:0] e_aiv, e_od;
      isz = in_q.size();
      osz = out_q.size();
      e_aiv = 8'h00;
      e_od = 8'h00;
      if (aie && isz > 0) e_aiv = in_q[0];
      if (osz > 0) e_od = out_q[0];
      #1;
      check("arch_input_value", 32'(arch_input_value), 32'(e_aiv));
      check("cpu_stall", 32'(cpu_stall), 32'(aie && isz == 0));
      check("in_ready", 32'(in_ready), 32'(isz < DEPTH));
      check("out_valid", 32'(out_valid), 32'(osz > 0));
      check("out_data", 32'(out_data), 32'(e_od));
      last_aiv = arch_input_value;
      last_od = out_data;
      last_ir = in_ready;
      last_stall = cpu_stall;
      @(posedge clk);
      if (!rst) begin
         in_q.delete();
         out_q.delete();
         m_uf = 1'b0;
         m_of = 1'b0;
      end else begin
         ipop = aie && isz > 0;
         ipush = in_valid && isz < DEPTH;
         under = aie && isz == 0;
         if (ipop) void'(in_q.pop_front());
         if (ipush) in_q.push_back(in_data);
         opop = out_ready && osz > 0;
         drop = aoe && osz == DEPTH && !opop;
         if (opop) void'(out_q.pop_front());
         if (aoe && !drop) out_q.push_back(aov);
         m_uf = under ? 1'b1 : (clr ? 1'b0 : m_uf);
         m_of = drop ? 1'b1 : (clr ? 1'b0 : m_of);
      end
      #1;
      check("in_count", 32'(in_count), 32'(in_q.size()));
      check("out_count", 32'(out_count), 32'(out_q.size()));
      check("in_underflow", 32'(in_underflow), 32'(m_uf));
      check("out_overflow", 32'(out_overflow), 32'(m_of));
   endtask

   task automatic push_in(input logic [7:0] d);
      idle(); in_valid = 1'b1; in_data = d; tick();
   endtask

   task automatic read_in();
      idle(); aie = 1'b1; tick();
   endtask

   task automatic core_out(input logic [7:0] d, input logic rdy);
      idle(); aoe = 1'b1; aov = d; out_ready = rdy; tick();
   endtask

   task automatic drain();
      idle(); out_ready = 1'b1; tick();
   endtask

   initial begin
      // unchecked power-up reset, then checked reset cycle with the core requesting input
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      idle(); rst = 1'b0; aie = 1'b1; tick();
      check("rst_stall", 32'(last_stall), 32'd1);
      check("rst_in_count", 32'(in_count), 32'd0);

      // input order
      push_in(8'h11); push_in(8'h22); push_in(8'h33);
      check("order_count3", 32'(in_count), 32'd3);
      read_in(); check("order_rd0", 32'(last_aiv), 32'h11);
      read_in(); check("order_rd1", 32'(last_aiv), 32'h22);
      read_in(); check("order_rd2", 32'(last_aiv), 32'h33);
      check("order_count0", 32'(in_count), 32'd0);
      check("order_uf", 32'(in_underflow), 32'd0);

      // read while empty, then clear
      read_in();
      check("empty_val", 32'(last_aiv), 32'h00);
      check("empty_stall", 32'(last_stall), 32'd1);
      check("empty_uf", 32'(in_underflow), 32'd1);
      idle(); clr = 1'b1; tick();
      check("clear_uf", 32'(in_underflow), 32'd0);

      // no bypass: push and read together while empty
      idle(); aie = 1'b1; in_valid = 1'b1; in_data = 8'h9E; tick();
      check("nobypass_val", 32'(last_aiv), 32'h00);
      check("nobypass_cnt", 32'(in_count), 32'd1);
      read_in(); check("nobypass_rd", 32'(last_aiv), 32'h9E);
      idle(); clr = 1'b1; tick();

      // input full plus three wrap-around passes
      for (int i = 0; i <= DEPTH; i++) push_in(8'(8'h40 + i));
      check("full_ready", 32'(last_ir), 32'd0);
      check("full_count", 32'(in_count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         read_in(); check("full_rd", 32'(last_aiv), 32'(8'h40 + i));
      end
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < DEPTH; i++) push_in(8'(c * 16 + i));
         for (int i = 0; i < DEPTH; i++) begin
            read_in(); check("wrap_rd", 32'(last_aiv), 32'(c * 16 + i));
         end
      end

      // output full with drop
      for (int i = 0; i <= DEPTH; i++) core_out(8'(8'hA0 + i), 1'b0);
      check("ofull_count", 32'(out_count), 32'(DEPTH));
      check("ofull_ovf", 32'(out_overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         drain(); check("ofull_drain", 32'(last_od), 32'(8'hA0 + i));
      end
      check("ofull_empty", 32'(out_valid), 32'd0);
      idle(); clr = 1'b1; tick();
      check("clear_ovf", 32'(out_overflow), 32'd0);

      // output full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) core_out(8'(8'h50 + i), 1'b0);
      core_out(8'h5C, 1'b1);
      check("simul_ovf", 32'(out_overflow), 32'd0);
      check("simul_count", 32'(out_count), 32'(DEPTH));
      for (int i = 1; i < DEPTH; i++) begin
         drain(); check("simul_drain", 32'(last_od), 32'(8'h50 + i));
      end
      drain(); check("simul_last", 32'(last_od), 32'h5C);

      // reset mid-stream with flags set
      for (int i = 0; i < DEPTH / 2; i++) begin
         idle(); in_valid = 1'b1; in_data = 8'(8'h60 + i); aoe = 1'b1; aov = 8'(8'h70 + i); tick();
      end
      read_in(); read_in(); read_in(); read_in(); read_in();
      idle(); rst = 1'b0; aoe = 1'b1; in_valid = 1'b1; tick();
      check("midrst_in", 32'(in_count), 32'd0);
      check("midrst_out", 32'(out_count), 32'd0);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_uf", 32'(in_underflow), 32'd0);
      push_in(8'h77); read_in(); check("midrst_rt_in", 32'(last_aiv), 32'h77);
      core_out(8'h88, 1'b0); drain(); check("midrst_rt_out", 32'(last_od), 32'h88);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         idle();
         aie = ($urandom_range(0, 9) < 4);
         aoe = ($urandom_range(0, 9) < 4);
         in_valid = ($urandom_range(0, 9) < 5);
         out_ready = ($urandom_range(0, 9) < 5);
         clr = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 99) != 0);
         in_data = 8'($urandom);
         aov = 8'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
